// File: rtl/rx_frame_des.sv
// rx_frame_des: CDBUS receive-side frame deserializer.
// Recovers UART characters from rx, writes frame bytes to RAM, checks CRC-16/MODBUS.
module rx_frame_des (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] period_ls,
    input  logic [15:0] period_hs,
    input  logic [9:0]  idle_wait_len,
    input  logic [7:0]  filter,
    input  logic        user_crc,
    input  logic        buf_free,
    input  logic        rx,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        wr_en,
    output logic        frame_done,
    output logic        frame_lost,
    output logic        crc_err,
    output logic        rx_err,
    output logic        tx_permit
);

    typedef enum logic [2:0] {
        WAIT_IDLE,
        WAIT_START,
        START,
        BITS,
        STOP,
        DROP
    } state_e;

    state_e      state_q, state_d;

    logic        rx_meta_q, rx_meta_d;
    logic        rx_s_q, rx_s_d;
    logic [15:0] period_cnt_q, period_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [8:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  len_q, len_d;
    logic        hs_flag_q, hs_flag_d;
    logic [15:0] crc_q, crc_d;
    logic [15:0] idle_tick_q, idle_tick_d;
    logic [9:0]  idle_cnt_q, idle_cnt_d;
    logic        fin_q, fin_d;
    logic        fin_ok_q, fin_ok_d;

    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        wr_en_q, wr_en_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_lost_q, frame_lost_d;
    logic        crc_err_q, crc_err_d;
    logic        rx_err_q, rx_err_d;
    logic        tx_permit_q, tx_permit_d;

    logic        rx_s;
    logic [15:0] period_cur;
    logic [15:0] half;
    logic        sample;
    logic        cnt_wrap;
    logic        idle_hit;
    logic        in_frame;
    logic        last_byte;
    logic        lost;
    logic        filt_miss;
    logic        stop_smp;
    logic        stop_err;
    logic        stop_ok;
    logic        do_wr;
    logic        timeout;
    logic        bit_smp;
    logic        frame_clr;

    function automatic logic [15:0] crc_bit(
        input logic [15:0] c,
        input logic        b
    );
        logic [15:0] s;
        s = c >> 1;
        if (c[0] ^ b) begin
            s = s ^ 16'hA001;
        end
        return s;
    endfunction

    assign rx_s       = rx_s_q;
    assign period_cur = hs_flag_q ? period_hs : period_ls;
    assign half       = {1'b0, period_cur[15:1]};
    assign sample     = (period_cnt_q == half);
    assign cnt_wrap   = (period_cnt_q >= period_cur);
    assign idle_hit   = (idle_cnt_q >= idle_wait_len);
    assign in_frame   = (byte_cnt_q != 9'd0);
    assign last_byte  = (byte_cnt_q == ({1'b0, len_q} + 9'd4));
    assign lost       = !in_frame && !buf_free;
    assign filt_miss  = (byte_cnt_q == 9'd1) && (filter != 8'hFF)
                     && (shift_q != filter) && (shift_q != 8'hFF);
    assign stop_smp   = (state_q == STOP) && sample;
    assign stop_err   = stop_smp && !rx_s;
    assign stop_ok    = stop_smp && rx_s;
    assign do_wr      = stop_ok && !lost;
    assign timeout    = (state_q == WAIT_START) && in_frame && idle_hit;
    assign bit_smp    = (state_q == BITS) && sample;

    // Anything that ends or abandons the current frame.
    assign frame_clr  = stop_err || (stop_ok && lost) || timeout
                     || (do_wr && (last_byte || filt_miss));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WAIT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_IDLE: begin
                if (idle_hit) state_d = WAIT_START;
            end
            WAIT_START: begin
                if (!timeout && !rx_s) state_d = START;
            end
            START: begin
                if (sample) state_d = rx_s ? WAIT_START : BITS;
            end
            BITS: begin
                if (sample && bit_cnt_q == 3'd7) state_d = STOP;
            end
            STOP: begin
                if (sample) begin
                    if (!rx_s) begin
                        state_d = WAIT_IDLE;
                    end else if (lost || filt_miss) begin
                        state_d = DROP;
                    end else begin
                        state_d = WAIT_START;
                    end
                end
            end
            DROP: begin
                if (idle_hit) state_d = WAIT_IDLE;
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    always_comb begin
        rx_meta_d    = rx;
        rx_s_d       = rx_meta_q;

        period_cnt_d = 16'd0;
        if (state_q == START || state_q == BITS || state_q == STOP) begin
            period_cnt_d = cnt_wrap ? 16'd0 : period_cnt_q + 16'd1;
        end

        bit_cnt_d = bit_cnt_q;
        if (state_q == START) bit_cnt_d = 3'd0;
        if (bit_smp) bit_cnt_d = bit_cnt_q + 3'd1;

        shift_d = shift_q;
        crc_d   = crc_q;
        if (bit_smp) begin
            shift_d = {rx_s, shift_q[7:1]};
            crc_d   = crc_bit(crc_q, rx_s);
        end

        byte_cnt_d = byte_cnt_q;
        hs_flag_d  = hs_flag_q;
        if (frame_clr) begin
            byte_cnt_d = 9'd0;
            hs_flag_d  = 1'b0;
            crc_d      = 16'hFFFF;
        end else if (do_wr) begin
            byte_cnt_d = byte_cnt_q + 9'd1;
            hs_flag_d  = 1'b1;
        end

        len_d = len_q;
        if (do_wr && byte_cnt_q == 9'd2) len_d = shift_q;

        // Idle time is always measured in low-speed bit periods.
        idle_tick_d = 16'd0;
        idle_cnt_d  = 10'd0;
        if (rx_s) begin
            idle_tick_d = (idle_tick_q >= period_ls) ? 16'd0
                                                     : idle_tick_q + 16'd1;
            idle_cnt_d  = idle_cnt_q;
            if (idle_tick_q >= period_ls && !idle_hit) begin
                idle_cnt_d = idle_cnt_q + 10'd1;
            end
        end

        fin_d    = do_wr && last_byte;
        fin_ok_d = (crc_q == 16'h0000) || user_crc;

        wr_en_d   = do_wr;
        wr_addr_d = do_wr ? byte_cnt_q[7:0] : wr_addr_q;
        wr_data_d = do_wr ? shift_q : wr_data_q;

        frame_done_d = fin_q && fin_ok_q;
        crc_err_d    = fin_q && !fin_ok_q;
        frame_lost_d = stop_ok && lost;
        rx_err_d     = stop_err || timeout;

        tx_permit_d = tx_permit_q;
        if (!rx_s) begin
            tx_permit_d = 1'b0;
        end else if (idle_hit && !in_frame) begin
            tx_permit_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            period_cnt_q <= 16'd0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            byte_cnt_q   <= 9'd0;
            len_q        <= 8'd0;
            hs_flag_q    <= 1'b0;
            crc_q        <= 16'hFFFF;
            idle_tick_q  <= 16'd0;
            idle_cnt_q   <= 10'd0;
            fin_q        <= 1'b0;
            fin_ok_q     <= 1'b0;
            wr_addr_q    <= 8'd0;
            wr_data_q    <= 8'd0;
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            frame_lost_q <= 1'b0;
            crc_err_q    <= 1'b0;
            rx_err_q     <= 1'b0;
            tx_permit_q  <= 1'b0;
        end else begin
            rx_meta_q    <= rx_meta_d;
            rx_s_q       <= rx_s_d;
            period_cnt_q <= period_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_cnt_q   <= byte_cnt_d;
            len_q        <= len_d;
            hs_flag_q    <= hs_flag_d;
            crc_q        <= crc_d;
            idle_tick_q  <= idle_tick_d;
            idle_cnt_q   <= idle_cnt_d;
            fin_q        <= fin_d;
            fin_ok_q     <= fin_ok_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_en_q      <= wr_en_d;
            frame_done_q <= frame_done_d;
            frame_lost_q <= frame_lost_d;
            crc_err_q    <= crc_err_d;
            rx_err_q     <= rx_err_d;
            tx_permit_q  <= tx_permit_d;
        end
    end

    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_en      = wr_en_q;
    assign frame_done = frame_done_q;
    assign frame_lost = frame_lost_q;
    assign crc_err    = crc_err_q;
    assign rx_err     = rx_err_q;
    assign tx_permit  = tx_permit_q;

endmodule

// File: tb/tb_rx_frame_des.sv
// tb_rx_frame_des: directed bench for the CDBUS receive deserializer.
// Drives UART-style frames on rx and checks RAM writes and status pulses.
module tb_rx_frame_des;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] period_ls;
    logic [15:0] period_hs;
    logic [9:0]  idle_wait_len;
    logic [7:0]  filter;
    logic        user_crc;
    logic        buf_free;
    logic        rx;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic        frame_done;
    logic        frame_lost;
    logic        crc_err;
    logic        rx_err;
    logic        tx_permit;

    rx_frame_des dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .period_ls     (period_ls),
        .period_hs     (period_hs),
        .idle_wait_len (idle_wait_len),
        .filter        (filter),
        .user_crc      (user_crc),
        .buf_free      (buf_free),
        .rx            (rx),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_en         (wr_en),
        .frame_done    (frame_done),
        .frame_lost    (frame_lost),
        .crc_err       (crc_err),
        .rx_err        (rx_err),
        .tx_permit     (tx_permit)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         nwr = 0, ndone = 0, nlost = 0, ncrc = 0, nrxe = 0, nperm = 0;
    int         b_wr, b_done, b_lost, b_crc, b_rxe, b_perm;
    logic [7:0] wa [0:1023];
    logic [7:0] wd [0:1023];
    logic [7:0] fr [0:5];
    bit         busy = 1'b0;

    // Event recorder; checks below work on deltas of these counts.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (wr_en) begin
                if (nwr < 1024) begin
                    wa[nwr] <= wr_addr;
                    wd[nwr] <= wr_data;
                end
                nwr <= nwr + 1;
            end
            if (frame_done) ndone <= ndone + 1;
            if (frame_lost) nlost <= nlost + 1;
            if (crc_err)    ncrc  <= ncrc + 1;
            if (rx_err)     nrxe  <= nrxe + 1;
            if (busy && tx_permit) nperm <= nperm + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_wr   = nwr;
        b_done = ndone;
        b_lost = nlost;
        b_crc  = ncrc;
        b_rxe  = nrxe;
        b_perm = nperm;
    endtask

    task automatic send_bit(input logic v, input int clks);
        rx = v;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit hs,
                             input logic stopv, input bit mark);
        int n;
        n = hs ? 4 : 40;
        send_bit(1'b0, 4);
        if (mark) busy = 1'b1;
        send_bit(1'b0, n - 4);
        for (int i = 0; i < 8; i++) send_bit(b[i], n);
        send_bit(stopv, n);
    endtask

    task automatic send_frame(input int n);
        for (int i = 0; i < n; i++) begin
            send_byte(fr[i], i != 0, 1'b1, i == 0);
        end
        busy = 1'b0;
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * 40) @(negedge clk);
    endtask

    // Frame src, dst, len=1, one data byte, CRC-16/MODBUS little-endian.
    task automatic build(input logic [7:0] s, input logic [7:0] d,
                         input logic [7:0] x, input bit bad);
        logic [15:0] c;
        fr[0] = s;
        fr[1] = d;
        fr[2] = 8'h01;
        fr[3] = x;
        c = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            c = c ^ {8'h00, fr[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
            end
        end
        fr[4] = c[7:0];
        fr[5] = c[15:8] ^ {7'd0, bad};
    endtask

    task automatic chk_writes(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_wr%0d", tag, i),
                {16'd0, wa[b_wr + i], wd[b_wr + i]},
                {16'd0, i[7:0], fr[i]});
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        rx            = 1'b1;
        period_ls     = 16'd39;
        period_hs     = 16'd3;
        idle_wait_len = 10'd10;
        filter        = 8'h02;
        user_crc      = 1'b0;
        buf_free      = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outs", {10'd0, wr_addr, wr_data, wr_en, frame_done,
            frame_lost, crc_err, rx_err, tx_permit}, 32'd0);
        reset_n = 1'b1;

        idle_bits(5);
        chk("permit_early", tx_permit, 0);
        idle_bits(7);
        chk("permit_idle", tx_permit, 1);

        // Good frame
        build(8'h01, 8'h02, 8'hAA, 1'b0);
        snap();
        send_frame(6);
        idle_bits(2);
        chk("t1_nwr", nwr - b_wr, 6);
        chk_writes("t1", 6);
        chk("t1_done", ndone - b_done, 1);
        chk("t1_crcerr", ncrc - b_crc, 0);
        chk("t1_permit_busy", nperm - b_perm, 0);
        idle_bits(10);

        // Corrupted CRC
        build(8'h01, 8'h02, 8'hAA, 1'b1);
        snap();
        send_frame(6);
        idle_bits(2);
        chk("t2_nwr", nwr - b_wr, 6);
        chk("t2_crcerr", ncrc - b_crc, 1);
        chk("t2_done", ndone - b_done, 0);
        idle_bits(10);

        // Corrupted CRC, CRC check bypassed
        user_crc = 1'b1;
        snap();
        send_frame(6);
        idle_bits(2);
        chk("t2u_done", ndone - b_done, 1);
        chk("t2u_crcerr", ncrc - b_crc, 0);
        user_crc = 1'b0;
        idle_bits(10);

        // Address filter miss
        build(8'h01, 8'h05, 8'h33, 1'b0);
        snap();
        send_frame(6);
        idle_bits(12);
        chk("t3_nwr", nwr - b_wr, 2);
        chk_writes("t3", 2);
        chk("t3_pulses", (ndone - b_done) + (ncrc - b_crc), 0);
        chk("t3_permit", tx_permit, 1);

        // Broadcast destination
        build(8'h01, 8'hFF, 8'h5C, 1'b0);
        snap();
        send_frame(6);
        idle_bits(2);
        chk("t3b_nwr", nwr - b_wr, 6);
        chk("t3b_done", ndone - b_done, 1);
        idle_bits(10);

        // No free page
        build(8'h07, 8'h02, 8'h11, 1'b0);
        buf_free = 1'b0;
        snap();
        send_frame(6);
        buf_free = 1'b1;
        idle_bits(12);
        chk("t4_lost", nlost - b_lost, 1);
        chk("t4_nwr", nwr - b_wr, 0);
        chk("t4_done", ndone - b_done, 0);
        snap();
        send_frame(6);
        idle_bits(2);
        chk("t4b_nwr", nwr - b_wr, 6);
        chk_writes("t4b", 6);
        chk("t4b_done", ndone - b_done, 1);
        idle_bits(10);

        // Stop bit low on byte 2
        build(8'h03, 8'h02, 8'h44, 1'b0);
        snap();
        send_byte(fr[0], 1'b0, 1'b1, 1'b0);
        send_byte(fr[1], 1'b1, 1'b1, 1'b0);
        send_byte(fr[2], 1'b1, 1'b0, 1'b0);
        for (int i = 3; i < 6; i++) send_byte(fr[i], 1'b1, 1'b1, 1'b0);
        idle_bits(12);
        chk("t5_rxerr", nrxe - b_rxe, 1);
        chk("t5_nwr", nwr - b_wr, 2);
        chk("t5_pulses", (ndone - b_done) + (ncrc - b_crc), 0);
        snap();
        send_frame(6);
        idle_bits(2);
        chk("t5b_done", ndone - b_done, 1);
        idle_bits(10);

        // 0.3-bit glitch on idle line
        chk("t6_permit_pre", tx_permit, 1);
        snap();
        send_bit(1'b0, 12);
        send_bit(1'b1, 5);
        chk("t6_permit_drop", tx_permit, 0);
        idle_bits(9);
        chk("t6_permit_9", tx_permit, 0);
        idle_bits(2);
        chk("t6_permit_11", tx_permit, 1);
        chk("t6_nwr", nwr - b_wr, 0);
        chk("t6_rxerr", nrxe - b_rxe, 0);

        // Inter-byte timeout after byte 3
        build(8'h01, 8'h02, 8'hAA, 1'b0);
        snap();
        send_frame(4);
        idle_bits(9);
        chk("t7_rxerr_9", nrxe - b_rxe, 0);
        chk("t7_permit_9", tx_permit, 0);
        idle_bits(3);
        chk("t7_rxerr_12", nrxe - b_rxe, 1);
        chk("t7_permit_12", tx_permit, 1);
        chk("t7_nwr", nwr - b_wr, 4);
        chk("t7_pulses", (ndone - b_done) + (ncrc - b_crc), 0);

        // Reset in the middle of byte 3
        build(8'h09, 8'h02, 8'h77, 1'b0);
        send_frame(3);
        rx = 1'b0;
        repeat (20) @(negedge clk);
        chk("t8_addr_pre", wr_addr, 2);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("t8_reset_outs", {10'd0, wr_addr, wr_data, wr_en, frame_done,
            frame_lost, crc_err, rx_err, tx_permit}, 32'd0);
        reset_n = 1'b1;
        rx = 1'b1;
        snap();
        idle_bits(12);
        chk("t8_no_pulses", (nwr - b_wr) + (ndone - b_done) + (nrxe - b_rxe)
            + (ncrc - b_crc) + (nlost - b_lost), 0);
        chk("t8_permit", tx_permit, 1);
        snap();
        send_frame(6);
        idle_bits(2);
        chk("t8b_nwr", nwr - b_wr, 6);
        chk_writes("t8b", 6);
        chk("t8b_done", ndone - b_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
